// File: rtl/regfile_stream_port.sv
// Streams a register range out over tx (dump) or in from rx (load); dump costs 2 cycles/word, load 1 cycle/word.
// tx words hold until tx_ready; rx_ready is high only in LOAD; abort or reset ends a transfer with no done pulse.
module regfile_stream_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] RegRead1,
  input  logic [DATA_W-1:0] ReadData1,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur, w_cur_nxt;
  logic [ADDR_W-1:0] r_last, w_last_nxt;
  logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic              w_last_word;
  logic [ADDR_W-1:0] w_cur_inc;

  assign w_last_word = (r_cur == r_last);
  // Index increment wraps naturally, giving the 15->0 range wrap.
  assign w_cur_inc   = r_cur + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_last     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_last     <= w_last_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_last_nxt     = r_last;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cur_nxt   = first_reg;
          w_last_nxt  = last_reg;
          w_state_nxt = mode ? S_LOAD : S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_state_nxt    = S_IDLE;
          w_tx_valid_nxt = 1'b0;
        end else begin
          w_tx_data_nxt  = ReadData1;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          w_state_nxt    = S_IDLE;
          w_tx_valid_nxt = 1'b0;
        end else if (tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          if (w_last_word) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cur_nxt   = w_cur_inc;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (rx_valid) begin
          if (w_last_word) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cur_nxt = w_cur_inc;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (r_state == S_FETCH) || (r_state == S_SEND) || (r_state == S_LOAD);
  assign done      = (r_state == S_DONE);
  assign RegRead1  = r_cur;
  assign WriteReg  = r_cur;
  assign WriteData = rx_data;
  // The abort cycle itself must not commit the word on the rx bus.
  assign RegWrite  = (r_state == S_LOAD) && rx_valid && !abort;
  assign rx_ready  = (r_state == S_LOAD);
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;

endmodule

// File: tb/tb_regfile_stream_port.sv
// Bench for regfile_stream_port: register-file model plus tx/write scoreboards fed by each scenario task.
module tb_regfile_stream_port;
  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset, start, mode, abort, tx_ready, rx_valid;
  logic [AW-1:0] first_reg, last_reg;
  logic [DW-1:0] rx_data;
  logic          busy, done, RegWrite, tx_valid, rx_ready;
  logic [AW-1:0] RegRead1, WriteReg;
  logic [DW-1:0] ReadData1, WriteData, tx_data;

  int errors = 0;
  int checks = 0;
  int tx_words = 0, valid_cycles = 0, wr_count = 0, done_count = 0;

  logic [DW-1:0] tx_q[$];
  wr_t           wr_q[$];
  logic [DW-1:0] rf[16];
  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;

  regfile_stream_port #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .first_reg(first_reg), .last_reg(last_reg), .abort(abort),
    .busy(busy), .done(done), .RegRead1(RegRead1), .ReadData1(ReadData1),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    v = DW'(i) * 16'h1111 - 16'h1111;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
    end else if (RegWrite) begin
      rf[WriteReg] <= WriteData;
    end
  end
  assign ReadData1 = rf[RegRead1];

  // Output monitor: pops scoreboards on handshakes and checks tx stability under stall.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    wr_t           exp_w;
    if (reset !== 1'b1) begin
      if (tx_valid) valid_cycles++;
      if (prev_v && !prev_r) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_d) begin
          errors++;
          $display("FAIL tx_stable: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, prev_d);
        end
      end
      if (tx_valid && tx_ready) begin
        tx_words++;
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_word: got %h, no word expected", tx_data);
        end else begin
          exp_d = tx_q.pop_front();
          if (tx_data !== exp_d) begin
            errors++;
            $display("FAIL tx_word: got %h, required %h", tx_data, exp_d);
          end
        end
      end
      if (RegWrite) begin
        wr_count++;
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL reg_write: got R%0d=%h, no write expected", WriteReg, WriteData);
        end else begin
          exp_w = wr_q.pop_front();
          if (WriteReg !== exp_w.a || WriteData !== exp_w.d) begin
            errors++;
            $display("FAIL reg_write: got R%0d=%h, required R%0d=%h", WriteReg, WriteData, exp_w.a, exp_w.d);
          end
        end
      end
      if (done) done_count++;
    end
    prev_v = (reset === 1'b1) ? 1'b0 : tx_valid;
    prev_r = tx_ready;
    prev_d = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; mode = 0; abort = 0; tx_ready = 0; rx_valid = 0;
    first_reg = '0; last_reg = '0; rx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, RegWrite, rx_ready, tx_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/wr/rxr/txv=%b, required 00000", {busy, done, RegWrite, rx_ready, tx_valid});
    end
    checks++;
    if (RegRead1 !== 4'd0 || WriteReg !== 4'd0 || tx_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: rd=%0d wr=%0d txd=%h, required 0 0 0000", RegRead1, WriteReg, tx_data);
    end
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b done=%b wr=%b, required 0 0 0", busy, done, RegWrite);
    end
  endtask

  task automatic test_dump_basic();
    int cyc, w0, v0;
    tick();
    w0 = tx_words; v0 = valid_cycles;
    start = 1; mode = 0; first_reg = 4'd2; last_reg = 4'd4; tx_ready = 1;
    tx_q.push_back(16'h1111); tx_q.push_back(16'h2222); tx_q.push_back(16'h3333);
    tick();
    start = 0;
    wait_done(20, cyc);
    checks++;
    if (cyc != 7) begin
      errors++;
      $display("FAIL dump_done_cycle: done at cycle %0d, required 7", cyc);
    end
    checks++;
    if (tx_words - w0 != 3 || valid_cycles - v0 != 3) begin
      errors++;
      $display("FAIL dump_words: words=%0d valid_cycles=%0d, required 3 3", tx_words - w0, valid_cycles - v0);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL dump_end: busy=%b done=%b pending=%0d, required 0 0 0", busy, done, tx_q.size());
    end
  endtask

  task automatic test_dump_stall();
    int cyc, w0;
    tick();
    w0 = tx_words;
    start = 1; mode = 0; first_reg = 4'd5; last_reg = 4'd5; tx_ready = 0;
    tx_q.push_back(init_val(5));
    tick();
    start = 0;
    tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== init_val(5)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h, required 1 %h", k, tx_valid, tx_data, init_val(5));
      end
    end
    @(posedge clk); #1;
    tx_ready = 1;
    wait_done(5, cyc);
    checks++;
    if (cyc != 2 || tx_words - w0 != 1) begin
      errors++;
      $display("FAIL stall_done: done at %0d words=%0d, required 2 1", cyc, tx_words - w0);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, w0, wr0;
    tick();
    w0 = tx_words; wr0 = wr_count;
    start = 1; abort = 1; mode = 0; first_reg = 4'd8; last_reg = 4'd9; tx_ready = 1;
    tx_q.push_back(init_val(8)); tx_q.push_back(init_val(9));
    tick();
    start = 0; abort = 0;
    tick();
    start = 1; mode = 1; first_reg = 4'd0; last_reg = 4'd15;
    tick();
    start = 0;
    wait_done(10, cyc);
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL ignored_start_done: done at %0d, required 3", cyc);
    end
    checks++;
    if (tx_words - w0 != 2 || wr_count != wr0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL ignored_start_words: words=%0d writes=%0d pending=%0d, required 2 0 0", tx_words - w0, wr_count - wr0, tx_q.size());
    end
  endtask

  task automatic test_reset_mid_dump();
    int w0, d0;
    tick();
    w0 = tx_words; d0 = done_count;
    start = 1; mode = 0; first_reg = 4'd0; last_reg = 4'd7; tx_ready = 1;
    for (int i = 0; i < 8; i++) tx_q.push_back(init_val(i));
    tick();
    start = 0;
    tick(); tick(); tick();
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: tx_valid=%b, required 1", tx_valid);
    end
    reset = 1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: tx_valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
    tick(); tick();
    reset = 0;
    tx_q.delete();
    repeat (5) @(negedge clk);
    checks++;
    if (tx_words - w0 != 1 || done_count != d0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dump: words=%0d dones=%0d busy=%b txv=%b, required 1 0 0 0", tx_words - w0, done_count - d0, busy, tx_valid);
    end
  endtask

  task automatic test_load_wrap();
    int cyc, wr0;
    tick();
    wr0 = wr_count;
    start = 1; mode = 1; first_reg = 4'd14; last_reg = 4'd1; tx_ready = 0;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      rx_valid = 1; rx_data = 16'hA0 + DW'(k);
      wr_q.push_back('{a: AW'(14 + k), d: 16'hA0 + DW'(k)});
      #1;
      checks++;
      if (rx_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_rx_ready[%0d]: got %b, required 1", k, rx_ready);
      end
      tick();
    end
    rx_valid = 0;
    wait_done(3, cyc);
    checks++;
    if (cyc != 1 || wr_count - wr0 != 4 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL load_wrap_done: done at %0d writes=%0d pending=%0d, required 1 4 0", cyc, wr_count - wr0, wr_q.size());
    end
    checks++;
    if (rf[14] !== 16'hA0 || rf[15] !== 16'hA1 || rf[0] !== 16'hA2 || rf[1] !== 16'hA3) begin
      errors++;
      $display("FAIL load_wrap_regs: R14..R1=%h %h %h %h, required a0 a1 a2 a3", rf[14], rf[15], rf[0], rf[1]);
    end
  endtask

  task automatic test_load_toggle();
    int cyc, wr0, idx;
    logic [6:0] pat;
    pat = 7'b1010101;
    idx = 0;
    tick();
    wr0 = wr_count;
    start = 1; mode = 1; first_reg = 4'd0; last_reg = 4'd3;
    tick();
    start = 0;
    for (int k = 0; k < 7; k++) begin
      rx_valid = pat[k]; rx_data = 16'hB0 + DW'(k);
      if (pat[k]) begin
        wr_q.push_back('{a: AW'(idx), d: 16'hB0 + DW'(k)});
        idx++;
      end
      @(negedge clk);
      if (!pat[k]) begin
        checks++;
        if (RegWrite !== 1'b0) begin
          errors++;
          $display("FAIL toggle_idle_write[%0d]: RegWrite=%b, required 0", k, RegWrite);
        end
      end
      tick();
    end
    rx_valid = 0;
    wait_done(3, cyc);
    checks++;
    if (cyc != 1 || wr_count - wr0 != 4 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_done: done at %0d writes=%0d pending=%0d, required 1 4 0", cyc, wr_count - wr0, wr_q.size());
    end
  endtask

  task automatic test_abort_load();
    int wr0, d0;
    tick();
    wr0 = wr_count; d0 = done_count;
    start = 1; mode = 1; first_reg = 4'd0; last_reg = 4'd7;
    tick();
    start = 0;
    for (int k = 0; k < 2; k++) begin
      rx_valid = 1; rx_data = 16'hC0 + DW'(k);
      wr_q.push_back('{a: AW'(k), d: 16'hC0 + DW'(k)});
      tick();
    end
    rx_data = 16'hC2; abort = 1;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL abort_write: RegWrite=%b, required 0", RegWrite);
    end
    tick();
    abort = 0; rx_valid = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b rx_ready=%b, required 0 0", busy, rx_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_count != d0 || wr_count - wr0 != 2 || rf[2] !== 16'hB4 || rf[1] !== 16'hC1) begin
      errors++;
      $display("FAIL abort_result: dones=%0d writes=%0d R1=%h R2=%h, required 0 2 c1 b4", done_count - d0, wr_count - wr0, rf[1], rf[2]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dump_basic();
    test_dump_stall();
    test_start_ignored();
    test_reset_mid_dump();
    test_load_wrap();
    test_load_toggle();
    test_abort_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_stream_port.md
REGFILE_STREAM_PORT -- requirements
Module: regfile_stream_port

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter ADDR_W, default 4, register index width (16 registers).
REQ-003 SHALL have ports: clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: start  input  1  begin transfer when idle; mode  input  1  0=dump (regs->stream), 1=load (stream->regs).
REQ-006 SHALL have ports: first_reg, last_reg  input  ADDR_W  inclusive register range, sampled on accepted start.
REQ-007 SHALL have ports: abort  input  1  cancel transfer in progress.
REQ-008 SHALL have ports: busy  output  1  transfer active; done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports: RegRead1  output  ADDR_W  read address to register file; ReadData1  input  DATA_W  combinational read data.
REQ-010 SHALL have ports: WriteReg  output  ADDR_W; WriteData  output  DATA_W; RegWrite  output  1  register-file write port.
REQ-011 SHALL have ports: tx_data  output  DATA_W; tx_valid  output  1; tx_ready  input  1  outbound stream.
REQ-012 SHALL have ports: rx_data  input  DATA_W; rx_valid  input  1; rx_ready  output  1  inbound stream.

Function
REQ-013 SHALL implement states IDLE, FETCH, SEND, LOAD, DONE; busy=1 in FETCH/SEND/LOAD.
REQ-014 IDLE: start=1 SHALL latch mode, cur<=first_reg, last<=last_reg; next state FETCH (mode 0) or LOAD (mode 1).
REQ-015 start while not IDLE SHALL be ignored; range parameters SHALL not change mid-transfer.
REQ-016 Transfer length SHALL be ((last-first) mod 2^ADDR_W)+1 words; first>last wraps 15->0; first==last transfers one word.
REQ-017 RegRead1 SHALL equal cur in all states; WriteReg SHALL equal cur.
REQ-018 FETCH: tx_data<=ReadData1, tx_valid<=1, next SEND (one cycle).
REQ-019 SEND: tx_data and tx_valid SHALL hold stable until tx_ready=1; on tx_valid&tx_ready tx_valid<=0, then DONE if cur==last else cur<=cur+1 (mod 16) and FETCH.
REQ-020 Dump throughput SHALL be one word per 2 cycles with tx_ready held high.
REQ-021 LOAD: rx_ready SHALL be 1 (combinational, state-decoded); rx_ready SHALL be 0 in all other states.
REQ-022 LOAD with rx_valid=1: RegWrite=1, WriteData=rx_data same cycle (combinational); then DONE if cur==last else cur<=cur+1 (mod 16); one word per cycle.
REQ-023 RegWrite SHALL be 0 outside LOAD and in LOAD when rx_valid=0.
REQ-024 DONE: done=1 for exactly one cycle, next IDLE.
REQ-025 abort=1 in FETCH/SEND/LOAD SHALL force IDLE next cycle, tx_valid<=0, no done pulse; abort SHALL suppress RegWrite in that same cycle; abort in IDLE/DONE SHALL have no effect.
REQ-026 abort and start simultaneously in IDLE: start SHALL be accepted.

Reset
REQ-027 reset=1 SHALL asynchronously force state IDLE, cur=0, last=0, tx_data=0, tx_valid=0.
REQ-028 During and after reset: busy=0, done=0, RegWrite=0, rx_ready=0, RegRead1=0, WriteReg=0.
REQ-029 reset mid-transfer SHALL terminate it with no further RegWrite and no done pulse; restart requires new start.

Verification
REQ-030 Dump 2..4, regs = 0x1111,0x2222,0x3333, tx_ready=1 -> tx_data 0x1111,0x2222,0x3333 each valid one cycle, done at cycle 7 after start.
REQ-031 Load 14..1 (wrap), rx_valid=1 with 0xA0..0xA3 -> writes R14=0xA0,R15=0xA1,R0=0xA2,R1=0xA3, then done.
REQ-032 Dump 5..5 with tx_ready low 10 cycles -> tx_data/tx_valid stable 10 cycles, single word, then done.
REQ-033 Load 0..3, rx_valid toggling 1,0,1,0 -> RegWrite only on valid cycles, 4 writes total, done after fourth.
REQ-034 abort during Load after 2 words of 0..7 -> only R0,R1 written, no done, busy=0 next cycle; reset asserted mid-dump -> tx_valid=0 immediately.
REQ-035 start pulsed while busy -> ignored, range and word count unchanged.
